// File: rtl/apple_eat_detector_if.sv
// Apple-position bundle between snake control, apple generation and the eat detector.
// The detector connects through the slave modport; the producer side uses master.
interface apple_eat_detector_if #(
  parameter int unsigned SCORE_W = 8
);
  logic [1:0]         game_status;
  logic               move_tick;
  logic [5:0]         head_x, head_y;
  logic [5:0]         apple_x,  apple_y;
  logic [5:0]         apple2_x, apple2_y;
  logic [5:0]         apple3_x, apple3_y;
  logic [5:0]         apple4_x, apple4_y;
  logic [5:0]         apple5_x, apple5_y;
  logic               get_apple, get_apple2, get_apple3, get_apple4, get_apple5;
  logic               grow;
  logic [SCORE_W-1:0] score;

  modport master (
    output game_status, move_tick, head_x, head_y,
           apple_x, apple_y, apple2_x, apple2_y, apple3_x, apple3_y,
           apple4_x, apple4_y, apple5_x, apple5_y,
    input  get_apple, get_apple2, get_apple3, get_apple4, get_apple5, grow, score
  );

  modport slave (
    input  game_status, move_tick, head_x, head_y,
           apple_x, apple_y, apple2_x, apple2_y, apple3_x, apple3_y,
           apple4_x, apple4_y, apple5_x, apple5_y,
    output get_apple, get_apple2, get_apple3, get_apple4, get_apple5, grow, score
  );
endinterface

// File: rtl/apple_eat_detector.sv
// Detects the snake head landing on any of five apples, serialises relocate
// requests one at a time, and produces the grow pulse and saturating score.
module apple_eat_detector #(
  parameter int unsigned SCORE_W     = 8,
  parameter int unsigned ACK_TIMEOUT = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  apple_eat_detector_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, SCAN, REQ, WAIT} state_e;

  localparam logic [1:0]       ST_PLAYING = 2'b01;
  localparam logic [1:0]       ST_INIT    = 2'b11;
  localparam int unsigned      TW         = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0]    TMR_LAST   = TW'(ACK_TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [5:0]           hx_q, hx_d, hy_q, hy_d;
  logic [5:0]           sx_q, sx_d, sy_q, sy_d;
  logic                 flag_q, flag_d;
  logic [4:0]           pend_q, pend_d;
  logic [2:0]           k_q, k_d;
  logic [5:0]           ox_q, ox_d, oy_q, oy_d;
  logic [TW-1:0]        tmr_q, tmr_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [4:0]           ga_q, ga_d;
  logic                 grow_q, grow_d;

  logic [5:0]           ax [5];
  logic [5:0]           ay [5];
  logic [4:0]           hit;
  logic [4:0]           pend_src;
  logic [2:0]           sel;
  logic                 moved, issue, resume;

  assign ax[0] = bus.apple_x;   assign ay[0] = bus.apple_y;
  assign ax[1] = bus.apple2_x;  assign ay[1] = bus.apple2_y;
  assign ax[2] = bus.apple3_x;  assign ay[2] = bus.apple3_y;
  assign ax[3] = bus.apple4_x;  assign ay[3] = bus.apple4_y;
  assign ax[4] = bus.apple5_x;  assign ay[4] = bus.apple5_y;

  function automatic logic [2:0] lowest(input logic [4:0] v);
    logic found;
    lowest = 3'd0;
    found  = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      if (v[i] && !found) begin
        lowest = 3'(i);
        found  = 1'b1;
      end
    end
  endfunction

  always_comb begin
    for (int unsigned k = 0; k < 5; k++) begin
      hit[k] = (ax[k] == hx_q) && (ay[k] == hy_q);
    end
  end

  always_comb begin
    state_d  = state_q;
    hx_d     = hx_q;
    hy_d     = hy_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    flag_d   = flag_q;
    pend_d   = pend_q;
    k_d      = k_q;
    ox_d     = ox_q;
    oy_d     = oy_q;
    tmr_d    = tmr_q;
    score_d  = score_q;
    ga_d     = '0;
    grow_d   = 1'b0;
    issue    = 1'b0;
    resume   = 1'b0;
    pend_src = (state_q == SCAN) ? hit : pend_q;
    sel      = lowest(pend_src);
    moved    = (ax[k_q] != ox_q) || (ay[k_q] != oy_q);

    if (bus.game_status != ST_PLAYING) begin
      state_d = IDLE;
      pend_d  = '0;
      flag_d  = 1'b0;
      if (bus.game_status == ST_INIT) score_d = '0;
    end else begin
      if (state_q != IDLE && bus.move_tick) begin
        sx_d   = bus.head_x;
        sy_d   = bus.head_y;
        flag_d = 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (bus.move_tick) begin
            hx_d    = bus.head_x;
            hy_d    = bus.head_y;
            state_d = SCAN;
          end
        end
        SCAN: begin
          if (hit != '0) issue = 1'b1;
          else           resume = 1'b1;
        end
        REQ: begin
          ox_d    = ax[k_q];
          oy_d    = ay[k_q];
          tmr_d   = '0;
          state_d = WAIT;
        end
        WAIT: begin
          if (moved || tmr_q == TMR_LAST) begin
            if (pend_q != '0) issue = 1'b1;
            else              resume = 1'b1;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase

      // The pulse is registered on entry to REQ so it is visible during REQ itself.
      if (issue) begin
        ga_d[sel] = 1'b1;
        grow_d    = 1'b1;
        k_d       = sel;
        pend_d    = pend_src & ~(5'd1 << sel);
        state_d   = REQ;
        if (score_q != '1) score_d = score_q + 1'b1;
      end

      // Leaving a scan/request with nothing left: a saved tick takes precedence,
      // a tick arriving right now is either rescanned directly or re-saved behind it.
      if (resume) begin
        if (flag_q) begin
          hx_d    = sx_q;
          hy_d    = sy_q;
          flag_d  = bus.move_tick;
          state_d = SCAN;
        end else if (bus.move_tick) begin
          hx_d    = bus.head_x;
          hy_d    = bus.head_y;
          flag_d  = 1'b0;
          state_d = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      hx_q    <= '0;
      hy_q    <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      flag_q  <= 1'b0;
      pend_q  <= '0;
      k_q     <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      tmr_q   <= '0;
      score_q <= '0;
      ga_q    <= '0;
      grow_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hx_q    <= hx_d;
      hy_q    <= hy_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      flag_q  <= flag_d;
      pend_q  <= pend_d;
      k_q     <= k_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      tmr_q   <= tmr_d;
      score_q <= score_d;
      ga_q    <= ga_d;
      grow_q  <= grow_d;
    end
  end

  assign bus.get_apple  = ga_q[0];
  assign bus.get_apple2 = ga_q[1];
  assign bus.get_apple3 = ga_q[2];
  assign bus.get_apple4 = ga_q[3];
  assign bus.get_apple5 = ga_q[4];
  assign bus.grow       = grow_q;
  assign bus.score      = score_q;
endmodule

// File: tb/tb_apple_eat_detector.sv
// Bench for apple_eat_detector: two instances (8-bit and 2-bit score) share stimulus
// and are checked every cycle against a queue-based model plus directed literal checks.
`timescale 1ns/1ps
module tb_apple_eat_detector;
  localparam int unsigned ACK = 4;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic [1:0] st;
  logic       mt;
  logic [5:0] hx, hy;
  logic [5:0] ax [5];
  logic [5:0] ay [5];

  apple_eat_detector_if #(.SCORE_W(8)) bus8 ();
  apple_eat_detector_if #(.SCORE_W(2)) bus2 ();

  assign bus8.game_status = st;     assign bus2.game_status = st;
  assign bus8.move_tick   = mt;     assign bus2.move_tick   = mt;
  assign bus8.head_x      = hx;     assign bus2.head_x      = hx;
  assign bus8.head_y      = hy;     assign bus2.head_y      = hy;
  assign bus8.apple_x  = ax[0];  assign bus8.apple_y  = ay[0];
  assign bus8.apple2_x = ax[1];  assign bus8.apple2_y = ay[1];
  assign bus8.apple3_x = ax[2];  assign bus8.apple3_y = ay[2];
  assign bus8.apple4_x = ax[3];  assign bus8.apple4_y = ay[3];
  assign bus8.apple5_x = ax[4];  assign bus8.apple5_y = ay[4];
  assign bus2.apple_x  = ax[0];  assign bus2.apple_y  = ay[0];
  assign bus2.apple2_x = ax[1];  assign bus2.apple2_y = ay[1];
  assign bus2.apple3_x = ax[2];  assign bus2.apple3_y = ay[2];
  assign bus2.apple4_x = ax[3];  assign bus2.apple4_y = ay[3];
  assign bus2.apple5_x = ax[4];  assign bus2.apple5_y = ay[4];

  apple_eat_detector #(.SCORE_W(8), .ACK_TIMEOUT(ACK)) dut8 (
    .clock(clock), .reset_n(reset_n), .bus(bus8.slave));
  apple_eat_detector #(.SCORE_W(2), .ACK_TIMEOUT(ACK)) dut2 (
    .clock(clock), .reset_n(reset_n), .bus(bus2.slave));

  logic [4:0] ga8, ga2;
  assign ga8 = {bus8.get_apple5, bus8.get_apple4, bus8.get_apple3, bus8.get_apple2, bus8.get_apple};
  assign ga2 = {bus2.get_apple5, bus2.get_apple4, bus2.get_apple3, bus2.get_apple2, bus2.get_apple};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Reference model: a list of apples still to be served, a one-deep saved tick,
  // and a count of cycles spent waiting for the served apple to move.
  int         m_mode = 0;   // 0 idle, 1 scanning, 2 pulse issued, 3 waiting
  logic [5:0] m_cx, m_cy, m_tx, m_ty, m_ox, m_oy;
  bit         m_have = 1'b0;
  int         m_q[$];
  int         m_cur = 0;
  int         m_wait = 0;
  logic [4:0] e_ga = '0;
  logic       e_grow = 1'b0;
  int         e_s8 = 0;
  int         e_s2 = 0;

  task automatic m_fire();
    m_cur = m_q.pop_front();
    e_ga[m_cur] = 1'b1;
    e_grow = 1'b1;
    if (e_s8 < 255) e_s8++;
    if (e_s2 < 3) e_s2++;
    m_mode = 2;
  endtask

  task automatic m_next(inout bit tk);
    if (m_have) begin
      m_cx = m_tx; m_cy = m_ty; m_have = 1'b0; m_mode = 1;
    end else if (tk) begin
      m_cx = hx; m_cy = hy; tk = 1'b0; m_mode = 1;
    end else begin
      m_mode = 0;
    end
  endtask

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_mode = 0; m_have = 1'b0; m_q.delete();
      e_ga = '0; e_grow = 1'b0; e_s8 = 0; e_s2 = 0;
    end else begin
      bit tk;
      tk = mt;
      e_ga = '0;
      e_grow = 1'b0;
      if (st != 2'b01) begin
        m_mode = 0; m_have = 1'b0; m_q.delete();
        if (st == 2'b11) begin e_s8 = 0; e_s2 = 0; end
      end else begin
        case (m_mode)
          0: if (tk) begin m_cx = hx; m_cy = hy; m_mode = 1; tk = 1'b0; end
          1: begin
            m_q.delete();
            for (int i = 0; i < 5; i++)
              if (ax[i] == m_cx && ay[i] == m_cy) m_q.push_back(i);
            if (m_q.size() > 0) m_fire(); else m_next(tk);
          end
          2: begin m_ox = ax[m_cur]; m_oy = ay[m_cur]; m_wait = 0; m_mode = 3; end
          default: begin
            m_wait++;
            if (ax[m_cur] != m_ox || ay[m_cur] != m_oy || m_wait == ACK) begin
              if (m_q.size() > 0) m_fire(); else m_next(tk);
            end
          end
        endcase
        if (tk) begin m_have = 1'b1; m_tx = hx; m_ty = hy; end
      end
    end
  end

  always @(negedge clock) begin
    chk("get_apple_w8", int'(ga8), int'(e_ga));
    chk("grow_w8", int'(bus8.grow), int'(e_grow));
    chk("score_w8", int'(bus8.score), e_s8);
    chk("get_apple_w2", int'(ga2), int'(e_ga));
    chk("grow_w2", int'(bus2.grow), int'(e_grow));
    chk("score_w2", int'(bus2.score), e_s2);
    chk("onehot_w8", int'($onehot0(ga8)), 1);
  end

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic tick(input int x, input int y);
    mt = 1'b1; hx = 6'(x); hy = 6'(y);
    cyc();
    mt = 1'b0;
  endtask

  logic [4:0] resp;

  initial begin
    st = 2'($urandom); mt = 1'($urandom); hx = 6'($urandom); hy = 6'($urandom);
    for (int i = 0; i < 5; i++) begin ax[i] = 6'($urandom); ay[i] = 6'($urandom); end
    repeat (3) cyc();
    chk("reset_get_apple", int'(ga8), 0);
    chk("reset_grow", int'(bus8.grow), 0);
    chk("reset_score", int'(bus8.score), 0);

    st = 2'b01; mt = 1'b0;
    for (int i = 0; i < 5; i++) begin ax[i] = 6'(40 + i); ay[i] = 6'd50; end
    reset_n = 1'b1;
    repeat (4) cyc();
    chk("idle_get_apple", int'(ga8), 0);
    chk("idle_score", int'(bus8.score), 0);

    // single hit on apple3: pulse two cycles after the tick
    ax[2] = 6'd25; ay[2] = 6'd13;
    tick(25, 13);
    chk("hit3_not_early", int'(ga8), 0);
    cyc();
    chk("hit3_pulse", int'(ga8), 5'b00100);
    chk("hit3_grow", int'(bus8.grow), 1);
    chk("hit3_score", int'(bus8.score), 1);
    cyc(); ax[2] = 6'd33;
    chk("hit3_single", int'(ga8), 0);
    repeat (3) cyc();

    // apples 1 and 4 on the same cell: apple1 first, apple4 once apple1 moves
    ax[0] = 6'd20; ay[0] = 6'd9; ax[3] = 6'd20; ay[3] = 6'd9;
    tick(20, 9);
    cyc();
    chk("dual_first", int'(ga8), 5'b00001);
    chk("dual_score1", int'(bus8.score), 2);
    cyc(); ax[0] = 6'd1;
    chk("dual_gap", int'(ga8), 0);
    cyc();
    chk("dual_second", int'(ga8), 5'b01000);
    chk("dual_score2", int'(bus8.score), 3);
    cyc(); ax[3] = 6'd2;
    repeat (3) cyc();

    // apple2 never moves: timeout back to idle, a fresh tick then hits on time
    ax[1] = 6'd5; ay[1] = 6'd5;
    tick(5, 5);
    cyc();
    chk("timeout_pulse", int'(ga8), 5'b00010);
    for (int n = 0; n < 5; n++) begin
      cyc();
      chk("timeout_no_repeat", int'(ga8), 0);
    end
    tick(5, 5);
    cyc();
    chk("timeout_idle_again", int'(ga8), 5'b00010);
    chk("timeout_score", int'(bus8.score), 5);
    cyc(); ax[1] = 6'd3;
    repeat (3) cyc();

    // second tick during WAIT lands on apple5, served after the first request
    ax[0] = 6'd30; ay[0] = 6'd30; ax[4] = 6'd40; ay[4] = 6'd40;
    tick(30, 30);
    cyc();
    chk("queued_first", int'(ga8), 5'b00001);
    cyc();
    tick(40, 40);
    repeat (4) cyc();
    chk("queued_apple5", int'(ga8), 5'b10000);
    chk("queued_score", int'(bus8.score), 7);
    chk("sat_score_w2", int'(bus2.score), 3);
    cyc(); ax[0] = 6'd4; ax[4] = 6'd6;
    repeat (3) cyc();

    // leaving PLAYING mid-request abandons it; INITIALIZING clears the score
    ax[1] = 6'd7; ay[1] = 6'd7; ax[2] = 6'd7; ay[2] = 6'd7;
    tick(7, 7);
    cyc();
    chk("abort_pulse", int'(ga8), 5'b00010);
    st = 2'b10;
    repeat (4) begin
      cyc();
      chk("abort_quiet", int'(ga8), 0);
    end
    chk("abort_score_held", int'(bus8.score), 8);
    st = 2'b11;
    cyc();
    chk("init_score_w8", int'(bus8.score), 0);
    chk("init_score_w2", int'(bus2.score), 0);
    st = 2'b01;

    resp = '0;
    for (int n = 0; n < 4000; n++) begin
      cyc();
      for (int i = 0; i < 5; i++) begin
        if ((resp[i] && $urandom_range(0, 3) != 0) || $urandom_range(0, 49) == 0) begin
          ax[i] = 6'($urandom_range(0, 5));
          ay[i] = 6'($urandom_range(0, 5));
        end
      end
      resp = ga8;
      mt = ($urandom_range(0, 2) == 0);
      hx = 6'($urandom_range(0, 5));
      hy = 6'($urandom_range(0, 5));
      if ($urandom_range(0, 99) < 3) st = 2'($urandom_range(0, 3));
      else if ($urandom_range(0, 999) < 2) st = 2'b11;
      else st = 2'b01;
    end
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
